axi_tohost_monitor: RTL and testbench

AXI_TOHOST_MONITOR -- requirements
Module: axi_tohost_monitor

---
 rtl/axi_tohost_monitor.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_tohost_monitor.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tohost_monitor.sv
// rtl/axi_tohost_monitor.sv - passive AXI write snooper that decodes the tohost mailbox result
// Build option: define TOHOST_STRICT_B_EN to hold a capture until an OKAY write response retires it.
module axi_tohost_monitor #(
   parameter int                    ADDR_WIDTH  = 40,
   parameter int                    DATA_WIDTH  = 512,
   parameter int                    ID_WIDTH    = 4,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 40'h0080001000
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   input  logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   input  logic                    bready,
   output logic                    done_o,
   output logic                    pass_o,
   output logic [62:0]             exit_code_o,
   output logic                    err_o
);

   localparam int                    LANES    = DATA_WIDTH / 64;
   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LANE_SEL = (TOHOST_ADDR >> 3) & ADDR_WIDTH'(LANES - 1);
   localparam int                    LANE_IDX = int'(LANE_SEL);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
   } aw_entry_t;

   aw_entry_t             r_fifo [4];
   logic [1:0]            r_wr_ptr;
   logic [1:0]            r_rd_ptr;
   logic [2:0]            r_count;
   logic [7:0]            r_beat;
   logic                  r_done;
   logic                  r_pass;
   logic [62:0]           r_exit;
   logic                  r_err;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_bypass;
   logic                  w_beat_valid;
   aw_entry_t             w_in_entry;
   aw_entry_t             w_cur;
   logic                  w_len_end;
   logic                  w_last_evt;
   logic                  w_pop;
   logic                  w_push_req;
   logic                  w_push;
   logic [ADDR_WIDTH-1:0] w_bytes;
   logic [ADDR_WIDTH-1:0] w_aligned;
   logic [ADDR_WIDTH-1:0] w_incr;
   logic [ADDR_WIDTH-1:0] w_win_mask;
   logic [ADDR_WIDTH-1:0] w_wrap;
   logic [ADDR_WIDTH-1:0] w_beat_addr;
   logic [7:0]            w_lane_strb;
   logic [63:0]           w_lane_data;
   logic                  w_hit;
   logic                  w_cap;
   logic                  w_commit;
   logic [63:0]           w_commit_val;
   logic                  w_err_no_aw;
   logic                  w_err_ovf;
   logic                  w_err_last;
   logic                  w_err_rsvd;
   logic                  w_err_strict;
   logic                  w_err_evt;
   logic                  w_unused;

   assign w_aw_hs    = awvalid & awready;
   assign w_w_hs     = wvalid & wready;
   assign w_empty    = (r_count == 3'd0);
   assign w_full     = (r_count == 3'd4);
   assign w_in_entry = {awid, awaddr, awlen, awsize, awburst};

   // A W beat arriving alongside the first AW of an idle bus uses the AW fields directly.
   assign w_bypass     = w_aw_hs & w_w_hs & w_empty;
   assign w_beat_valid = w_w_hs & (~w_empty | w_aw_hs);
   assign w_cur        = w_empty ? w_in_entry : r_fifo[r_rd_ptr];

   // A burst ends on wlast or on the expected final beat, so a protocol slip never wedges the FIFO.
   assign w_len_end  = (r_beat == w_cur.len);
   assign w_last_evt = w_beat_valid & (wlast | w_len_end);
   assign w_pop      = w_last_evt & ~w_empty;
   assign w_push_req = w_aw_hs & ~(w_bypass & w_last_evt);
   assign w_push     = w_push_req & (~w_full | w_pop);

   assign w_err_no_aw = w_w_hs & w_empty & ~w_aw_hs;
   assign w_err_ovf   = w_push_req & w_full & ~w_pop;
   assign w_err_last  = w_beat_valid & (wlast != w_len_end);
   assign w_err_rsvd  = w_beat_valid & (w_cur.burst == 2'b11);

   // Wrap windows are power-of-two sized, so wrapping is a mask of the incrementing address.
   assign w_bytes    = ONE << w_cur.size;
   assign w_aligned  = w_cur.addr & ~(w_bytes - ONE);
   assign w_incr     = w_aligned + (ADDR_WIDTH'(r_beat) << w_cur.size);
   assign w_win_mask = ((ADDR_WIDTH'(w_cur.len) + ONE) << w_cur.size) - ONE;
   assign w_wrap     = (w_cur.addr & ~w_win_mask) | (w_incr & w_win_mask);

   // Select the byte address of the current beat from the burst type.
   always_comb begin
      w_beat_addr = w_cur.addr;
      case (w_cur.burst)
         BURST_FIXED: w_beat_addr = w_cur.addr;
         BURST_INCR:  w_beat_addr = w_incr;
         BURST_WRAP:  w_beat_addr = w_wrap;
         default:     w_beat_addr = w_cur.addr;
      endcase
   end

   assign w_lane_strb = wstrb[LANE_IDX*8 +: 8];
   assign w_lane_data = wdata[LANE_IDX*64 +: 64];
   assign w_hit = w_beat_valid & (w_cur.burst != 2'b11) &
                  (w_beat_addr[ADDR_WIDTH-1:3] == TOHOST_ADDR[ADDR_WIDTH-1:3]) &
                  (w_lane_strb == 8'hFF);
   // A zero write is the mailbox being cleared, not a result; nothing counts once done.
   assign w_cap = w_hit & (w_lane_data != 64'd0) & ~r_done;

`ifdef TOHOST_STRICT_B_EN
   logic                r_pend_valid;
   logic [ID_WIDTH-1:0] r_pend_id;
   logic [63:0]         r_pend_val;
   logic                w_b_match;

   assign w_b_match    = bvalid & bready & r_pend_valid & (bid == r_pend_id);
   assign w_commit     = w_b_match & (bresp == 2'b00) & ~r_done;
   assign w_commit_val = r_pend_val;
   assign w_err_strict = (w_b_match & (bresp != 2'b00)) | (w_cap & r_pend_valid & ~w_b_match);

   // Hold the newest capture until its write response arrives; any matching response retires it.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pend_valid <= 1'b0;
         r_pend_id    <= '0;
         r_pend_val   <= '0;
      end else if (w_cap) begin
         r_pend_valid <= 1'b1;
         r_pend_id    <= w_cur.id;
         r_pend_val   <= w_lane_data;
      end else if (w_b_match) begin
         r_pend_valid <= 1'b0;
      end
   end
`else
   assign w_commit     = w_cap;
   assign w_commit_val = w_lane_data;
   assign w_err_strict = 1'b0;
`endif

   assign w_err_evt = w_err_no_aw | w_err_ovf | w_err_last | w_err_rsvd | w_err_strict;

   // AW entry storage; validity is tracked by the pointers, so the payload needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= w_in_entry;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Beat position inside the burst currently on the W channel.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_beat <= 8'd0;
      end else if (w_last_evt) begin
         r_beat <= 8'd0;
      end else if (w_beat_valid) begin
         r_beat <= r_beat + 8'd1;
      end
   end

   // The first committed result freezes all result outputs until reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_exit <= '0;
      end else if (w_commit) begin
         r_done <= 1'b1;
         r_pass <= (w_commit_val == 64'd1);
         r_exit <= w_commit_val[63:1];
      end
   end

   // Sticky error flag.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_err <= 1'b0;
      end else if (w_err_evt) begin
         r_err <= 1'b1;
      end
   end

   assign done_o      = r_done;
   assign pass_o      = r_pass;
   assign exit_code_o = r_exit;
   assign err_o       = r_err;

   assign w_unused = ^{wdata, wstrb, bid, bresp, bvalid, bready, w_beat_addr[2:0], w_cur.id};

endmodule

// File: tb/tb_axi_tohost_monitor.sv
// tb/tb_axi_tohost_monitor.sv - self-checking bench for axi_tohost_monitor with a transaction-level model
module tb_axi_tohost_monitor;

   localparam int          AW = 40;
   localparam int          DW = 512;
   localparam int          IW = 4;
   localparam logic [39:0] T  = 40'h0080001000;
   localparam int          LANE = int'((T / 40'd8) % 40'd8);

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [IW-1:0] awid;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awvalid, awready;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic          wlast, wvalid, wready;
   logic [IW-1:0] bid;
   logic [1:0]    bresp;
   logic          bvalid, bready;
   logic          done_o, pass_o, err_o;
   logic [62:0]   exit_code_o;

   int n_checks;
   int n_errs;

   axi_tohost_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TOHOST_ADDR(T)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .done_o(done_o), .pass_o(pass_o), .exit_code_o(exit_code_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [3:0]      id;
      longint unsigned addr;
      int              len;
      int              size;
      int              burst;
   } m_aw_t;

   m_aw_t       mq[$];
   int          m_beat;
   logic        exp_done, exp_pass, exp_err;
   logic [62:0] exp_exit;
   logic        m_pend;
   logic [3:0]  m_pend_id;
   logic [63:0] m_pend_val;

   function automatic longint unsigned beat_address(input m_aw_t e, input int beat);
      longint unsigned sz, start, win, lower;
      sz    = 64'd1 << e.size;
      start = (e.addr / sz) * sz + longint'(beat) * sz;
      if (e.burst == 0) return e.addr;
      if (e.burst == 1) return start;
      win   = longint'(e.len + 1) * sz;
      lower = (e.addr / win) * win;
      return lower + (start % win);
   endfunction

   function automatic void m_commit(input logic [63:0] v);
      if (!exp_done) begin
         exp_done = 1'b1;
         exp_pass = (v == 64'd1);
         exp_exit = v[63:1];
      end
   endfunction

   task automatic model_step();
      bit aw_hs, w_hs, b_hs, err, have, bypass, last, len_end, done_before;
      m_aw_t cur, inc;
      longint unsigned a;
      logic [63:0] v;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      err = 0; have = 0; bypass = 0; last = 0;
      done_before = exp_done;
      inc.id = awid; inc.addr = longint'(awaddr); inc.len = int'(awlen);
      inc.size = int'(awsize); inc.burst = int'(awburst);
      cur = inc;
`ifdef TOHOST_STRICT_B_EN
      if (b_hs && m_pend && bid == m_pend_id) begin
         if (bresp == 2'b00) begin
            if (!done_before) m_commit(m_pend_val);
         end else begin
            err = 1;
         end
         m_pend = 0;
      end
`else
      if (b_hs) err = err;
`endif
      if (w_hs) begin
         if (mq.size() > 0) begin
            cur = mq[0]; have = 1;
         end else if (aw_hs) begin
            have = 1; bypass = 1;
         end else begin
            err = 1;
         end
         if (have) begin
            len_end = (m_beat == cur.len);
            last = wlast || len_end;
            if (wlast != len_end) err = 1;
            if (cur.burst == 3) begin
               err = 1;
            end else begin
               a = beat_address(cur, m_beat) & 64'hFF_FFFF_FFFF;
               v = wdata[LANE*64 +: 64];
               if ((a >> 3) == (longint'(T) >> 3) && wstrb[LANE*8 +: 8] == 8'hFF &&
                   v != 64'd0 && !done_before) begin
`ifdef TOHOST_STRICT_B_EN
                  if (m_pend) err = 1;
                  m_pend = 1; m_pend_id = cur.id; m_pend_val = v;
`else
                  m_commit(v);
`endif
               end
            end
            if (last) begin
               m_beat = 0;
               if (!bypass) mq.delete(0);
            end else begin
               m_beat++;
            end
         end
      end
      if (aw_hs && !(bypass && last)) begin
         if (mq.size() >= 4) err = 1;
         else mq.push_back(inc);
      end
      if (err) exp_err = 1'b1;
   endtask

   // Model advances on each clock edge; reset clears it immediately like the DUT.
   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mq.delete();
         m_beat = 0; exp_done = 0; exp_pass = 0; exp_exit = '0; exp_err = 0;
         m_pend = 0; m_pend_id = '0; m_pend_val = '0;
      end else begin
         model_step();
      end
   end

   // Cycle compare between DUT outputs and model, away from the active edge.
   always @(negedge clk_i) begin
      check("cyc_done", {63'd0, done_o}, {63'd0, exp_done});
      check("cyc_pass", {63'd0, pass_o}, {63'd0, exp_pass});
      check("cyc_exit", {1'b0, exit_code_o}, {1'b0, exp_exit});
      check("cyc_err",  {63'd0, err_o},  {63'd0, exp_err});
   end

   // ---------------- stimulus ----------------
   task automatic clear_inputs();
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 0; awready = 0;
      wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; wready = 0;
      bid = '0; bresp = '0; bvalid = 0; bready = 0;
   endtask

   task automatic do_reset();
      #2;
      rstn_i = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk_i);
      #2;
      rstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic set_aw(input logic [3:0] id, input logic [39:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
      awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst;
      awvalid = 1; awready = 1;
   endtask

   task automatic set_w(input logic [63:0] v, input logic [7:0] s, input logic last);
      wdata = {8{v}}; wstrb = {8{s}}; wlast = last; wvalid = 1; wready = 1;
   endtask

   task automatic aw(input logic [3:0] id, input logic [39:0] a, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst);
      set_aw(id, a, len, size, burst);
      @(negedge clk_i);
      awvalid = 0; awready = 0;
   endtask

   task automatic wbeat(input logic [63:0] v, input logic [7:0] s, input logic last);
      set_w(v, s, last);
      @(negedge clk_i);
      wvalid = 0; wready = 0; wlast = 0;
   endtask

   task automatic bresp_send(input logic [3:0] id, input logic [1:0] r);
      bid = id; bresp = r; bvalid = 1; bready = 1;
      @(negedge clk_i);
      bvalid = 0; bready = 0;
   endtask

   logic [39:0] rb_addr  [12];
   logic [3:0]  rb_id    [12];
   logic [7:0]  rb_len   [12];
   logic [2:0]  rb_size  [12];
   logic [1:0]  rb_burst [12];

   initial begin
      n_checks = 0;
      n_errs   = 0;
      clear_inputs();
      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_done", {63'd0, done_o}, 64'd0);
      check("rst_pass", {63'd0, pass_o}, 64'd0);
      check("rst_exit", {1'b0, exit_code_o}, 64'd0);
      check("rst_err",  {63'd0, err_o},  64'd0);
      #2;
      rstn_i = 1'b1;
      @(negedge clk_i);

`ifndef TOHOST_STRICT_B_EN
      // single-beat pass
      aw(4'd1, T, 8'd0, 3'd3, 2'b01);
      check("s1_pre_done", {63'd0, done_o}, 64'd0);
      wbeat(64'h1, 8'hFF, 1'b1);
      check("s1_done", {63'd0, done_o}, 64'd1);
      check("s1_pass", {63'd0, pass_o}, 64'd1);
      check("s1_exit", {1'b0, exit_code_o}, 64'd0);

      // failing code, then a later pass write is ignored
      do_reset();
      aw(4'd1, T, 8'd0, 3'd3, 2'b01);
      wbeat(64'h55, 8'hFF, 1'b1);
      check("s2_pass", {63'd0, pass_o}, 64'd0);
      check("s2_exit", {1'b0, exit_code_o}, 64'h2A);
      aw(4'd1, T, 8'd0, 3'd3, 2'b01);
      wbeat(64'h1, 8'hFF, 1'b1);
      check("s2_hold_pass", {63'd0, pass_o}, 64'd0);
      check("s2_hold_exit", {1'b0, exit_code_o}, 64'h2A);

      // INCR burst hitting on beat 2
      do_reset();
      aw(4'd2, T - 40'd128, 8'd3, 3'd6, 2'b01);
      wbeat(64'h99, 8'hFF, 1'b0);
      wbeat(64'h99, 8'hFF, 1'b0);
      check("s3_pre_done", {63'd0, done_o}, 64'd0);
      wbeat(64'h3, 8'hFF, 1'b0);
      check("s3_done", {63'd0, done_o}, 64'd1);
      check("s3_exit", {1'b0, exit_code_o}, 64'd1);
      wbeat(64'h1, 8'hFF, 1'b1);
      check("s3_err", {63'd0, err_o}, 64'd0);

      // WRAP burst wrapping back onto the mailbox on beat 3
      do_reset();
      aw(4'd3, T + 40'd64, 8'd3, 3'd6, 2'b10);
      wbeat(64'h77, 8'hFF, 1'b0);
      wbeat(64'h77, 8'hFF, 1'b0);
      wbeat(64'h77, 8'hFF, 1'b0);
      check("s4_pre_done", {63'd0, done_o}, 64'd0);
      wbeat(64'h5, 8'hFF, 1'b1);
      check("s4_done", {63'd0, done_o}, 64'd1);
      check("s4_exit", {1'b0, exit_code_o}, 64'd2);
      check("s4_err", {63'd0, err_o}, 64'd0);
`endif

      // bypass: AW and W together on an empty FIFO; the entry must not linger
      do_reset();
      set_aw(4'd1, T, 8'd0, 3'd3, 2'b01);
      set_w(64'h1, 8'hFF, 1'b1);
      @(negedge clk_i);
      clear_inputs();
`ifndef TOHOST_STRICT_B_EN
      check("byp_done", {63'd0, done_o}, 64'd1);
`endif
      check("byp_err0", {63'd0, err_o}, 64'd0);
      wbeat(64'h0, 8'hFF, 1'b1);
      check("byp_err1", {63'd0, err_o}, 64'd1);

      // five AWs with no W overflow the FIFO
      do_reset();
      for (int i = 0; i < 4; i++) aw(4'(i), T + 40'd4096, 8'd0, 3'd3, 2'b01);
      check("ovf_err4", {63'd0, err_o}, 64'd0);
      aw(4'd4, T + 40'd4096, 8'd0, 3'd3, 2'b01);
      check("ovf_err5", {63'd0, err_o}, 64'd1);

      // full FIFO with simultaneous push and pop is clean
      do_reset();
      for (int i = 0; i < 4; i++) aw(4'(i), T + 40'd4096, 8'd0, 3'd3, 2'b01);
      set_aw(4'd9, T + 40'd4096, 8'd0, 3'd3, 2'b01);
      set_w(64'h0, 8'hFF, 1'b1);
      @(negedge clk_i);
      clear_inputs();
      check("full_pp_err", {63'd0, err_o}, 64'd0);
      for (int i = 0; i < 4; i++) wbeat(64'h0, 8'hFF, 1'b1);
      check("full_drain_err", {63'd0, err_o}, 64'd0);
      wbeat(64'h0, 8'hFF, 1'b1);
      check("full_extra_err", {63'd0, err_o}, 64'd1);

      // W with no AW
      do_reset();
      wbeat(64'h1, 8'hFF, 1'b1);
      check("noaw_err", {63'd0, err_o}, 64'd1);
      check("noaw_done", {63'd0, done_o}, 64'd0);

      // partial strobe never hits
      do_reset();
      aw(4'd1, T, 8'd0, 3'd3, 2'b01);
      wbeat(64'h1, 8'h0F, 1'b1);
      check("pstrb_done", {63'd0, done_o}, 64'd0);
      check("pstrb_err", {63'd0, err_o}, 64'd0);

      // reset mid-burst discards it
      do_reset();
      aw(4'd1, T + 40'd4096, 8'd1, 3'd3, 2'b01);
      wbeat(64'h9, 8'hFF, 1'b0);
      do_reset();
      wbeat(64'h1, 8'hFF, 1'b1);
      check("midrst_err", {63'd0, err_o}, 64'd1);
      check("midrst_done", {63'd0, done_o}, 64'd0);

`ifdef TOHOST_STRICT_B_EN
      do_reset();
      aw(4'd5, T, 8'd0, 3'd3, 2'b01);
      wbeat(64'h1, 8'hFF, 1'b1);
      check("strict_wait", {63'd0, done_o}, 64'd0);
      bresp_send(4'd5, 2'b00);
      check("strict_done", {63'd0, done_o}, 64'd1);
      check("strict_pass", {63'd0, pass_o}, 64'd1);
      do_reset();
      aw(4'd5, T, 8'd0, 3'd3, 2'b01);
      wbeat(64'h1, 8'hFF, 1'b1);
      bresp_send(4'd5, 2'b10);
      check("strict_slverr_done", {63'd0, done_o}, 64'd0);
      check("strict_slverr_err", {63'd0, err_o}, 64'd1);
`endif

      // randomized episodes checked by the model every cycle
      for (int ep = 0; ep < 60; ep++) begin
         int n_b, aw_i, w_i, w_beat, cyc;
         bit aw_pres, aw_hs_now, w_ok;
         logic [63:0] v;
         do_reset();
         n_b = 1 + int'($urandom % 10);
         for (int i = 0; i < n_b; i++) begin
            int r;
            r = int'($urandom % 20);
            rb_burst[i] = (r < 1) ? 2'b11 : (r < 5) ? 2'b00 : (r < 13) ? 2'b01 : 2'b10;
            rb_size[i]  = 3'($urandom % 7);
            rb_len[i]   = (rb_burst[i] == 2'b10) ? 8'((1 << (1 + $urandom % 4)) - 1) : 8'($urandom % 8);
            rb_id[i]    = 4'($urandom % 4);
            rb_addr[i]  = T - 40'd256 + 40'($urandom % 512);
            if (rb_burst[i] == 2'b10) rb_addr[i] = (rb_addr[i] >> rb_size[i]) << rb_size[i];
         end
         aw_i = 0; w_i = 0; w_beat = 0; cyc = 0;
         while ((aw_i < n_b || w_i < n_b) && cyc < 400) begin
            aw_pres = (aw_i < n_b) && ($urandom % 3 != 0) && ((aw_i - w_i) < 4 || $urandom % 8 == 0);
            if (aw_i < n_b) begin
               awid = rb_id[aw_i]; awaddr = rb_addr[aw_i]; awlen = rb_len[aw_i];
               awsize = rb_size[aw_i]; awburst = rb_burst[aw_i];
            end
            awvalid = aw_pres;
            awready = ($urandom % 4 != 0);
            aw_hs_now = aw_pres && awready;
            w_ok = (w_i < n_b) && (w_i < aw_i || (aw_hs_now && aw_i == w_i));
            wvalid = w_ok && ($urandom % 3 != 0);
            wready = ($urandom % 4 != 0);
            wlast = (w_i < n_b) ? ((w_beat == int'(rb_len[w_i])) ^ ($urandom % 40 == 0)) : 1'b0;
            case ($urandom % 4)
               0: v = 64'd0;
               1: v = 64'd1;
               2: v = 64'($urandom % 256);
               default: v = {$urandom, $urandom};
            endcase
            for (int k = 0; k < 16; k++) wdata[k*32 +: 32] = $urandom;
            wdata[LANE*64 +: 64] = v;
            wstrb = {$urandom, $urandom};
            wstrb[LANE*8 +: 8] = ($urandom % 8 == 0) ? 8'($urandom) : 8'hFF;
            bvalid = ($urandom % 4 == 0);
            bready = ($urandom % 2 == 0);
            bid    = 4'($urandom % 4);
            bresp  = ($urandom % 4 == 0) ? 2'b10 : 2'b00;
            @(negedge clk_i);
            if (aw_hs_now) aw_i++;
            if (wvalid && wready) begin
               if (w_beat == int'(rb_len[w_i])) begin
                  w_i++;
                  w_beat = 0;
               end else begin
                  w_beat++;
               end
            end
            cyc++;
         end
         clear_inputs();
         repeat (3) @(negedge clk_i);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
